// File: rtl/button_debouncer.sv
// Purpose: synchronise a raw push-button level into clk and debounce it into btnOut.
// Latency: btnOut follows a clean input change STABLE_CYCLES+3 edges after it is first sampled.
// Backpressure: none; the input is free-running and all outputs are valid every cycle.
//
// Optional build macro DEBOUNCE_GLITCH_CNT_EN builds the saturating rejected-change
// counter on glitchCnt; without it glitchCnt is tied to zero.
module button_debouncer #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnIn,
    output logic       btnOut,
    output logic       busy,
    output logic [7:0] glitchCnt
);

    // Last count value in a CHK state; reaching it with the input still held qualifies the change.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_LOW   = 2'd0,
        S_CHK_H = 2'd1,
        S_HIGH  = 2'd2,
        S_CHK_L = 2'd3
    } state_t;

    logic             s1;
    logic             s2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Two-flop synchroniser; s2 is the only copy of the button seen by the FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btnIn;
            s2 <= s1;
        end
    end

    // State and stability counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: a revert is checked before the terminal count, so it wins a tie.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_LOW: begin
                if (s2) begin
                    state_nxt = S_CHK_H;
                    cnt_nxt   = '0;
                end
            end
            S_CHK_H: begin
                if (!s2) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!s2) begin
                    state_nxt = S_CHK_L;
                    cnt_nxt   = '0;
                end
            end
            S_CHK_L: begin
                if (s2) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Moore outputs decoded from the state register: the CHK states keep the old level.
    always_comb begin
        btnOut = 1'b0;
        busy   = 1'b0;
        case (state)
            S_CHK_H: busy = 1'b1;
            S_HIGH:  btnOut = 1'b1;
            S_CHK_L: begin
                btnOut = 1'b1;
                busy   = 1'b1;
            end
            default: begin
                btnOut = 1'b0;
                busy   = 1'b0;
            end
        endcase
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic       glitch_evt;
    logic [7:0] glitch_q;

    // A glitch is any exit from a CHK state caused by the input reverting.
    assign glitch_evt = ((state == S_CHK_H) && !s2) || ((state == S_CHK_L) && s2);

    // Saturating rejected-change counter, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            glitch_q <= 8'h00;
        end else if (glitch_evt && (glitch_q != 8'hFF)) begin
            glitch_q <= glitch_q + 8'd1;
        end
    end

    assign glitchCnt = glitch_q;
`else
    assign glitchCnt = 8'h00;
`endif

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Front-end input conditioner for the 8-bit up counter design. Takes a raw mechanical push-button level and synchronises it into `clk`. It filters contact bounce with a per-edge stability counter and presents a clean debounced level, `btnOut`. That level feeds the one-pulser stage, which turns each press into a single count-enable pulse for the counter.

## Interface
- `STABLE_CYCLES`, default 1000000: number of consecutive cycles the synchronised input must hold a new level before `btnOut` follows it (10 ms at 100 MHz); legal range 2 .. 2^CNT_W-1.
- `CNT_W`, default 20: width of the stability counter.
- `clk`  in  1: single clock, all logic on rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `btnIn`  in  1: raw button level, asynchronous to `clk`, may bounce.
- `btnOut`  out  1: debounced level, registered (Moore output of FSM).
- `busy`  out  1: high while a candidate level change is being qualified.
- `glitchCnt`  out  8: saturating count of rejected (too-short) input changes.

## Operation
- Synchroniser: two flops, `btnIn` -> `s1` -> `s2`; `s2` is the only copy of the input used by the FSM.
- FSM states and transitions:
  - S_LOW (`btnOut`=0, `busy`=0): if `s2`=1, go to S_CHK_H and set cnt=0; otherwise stay.
  - S_CHK_H (`btnOut`=0, `busy`=1):
    - `s2`=0: return to S_LOW and increment `glitchCnt`.
    - `s2`=1 and cnt==STABLE_CYCLES-1: go to S_HIGH.
    - Otherwise cnt++.
  - S_HIGH (`btnOut`=1, `busy`=0): if `s2`=0, go to S_CHK_L and set cnt=0.
  - S_CHK_L (`btnOut`=1, `busy`=1): mirror of S_CHK_H. `s2`=1 returns to S_HIGH with a glitch increment; `s2`=0 with cnt==STABLE_CYCLES-1 goes to S_LOW.
- Simultaneous events: if `s2` reverts in the same cycle cnt reaches STABLE_CYCLES-1, the revert wins. The FSM returns to the old stable state, a glitch is counted, and `btnOut` does not change.
- cnt counts only in the CHK states. It is CNT_W bits and never wraps, because the compare terminates it first.
- `glitchCnt` saturates at 8'hFF and holds. It is cleared only by reset.
- Unused state encodings recover to S_LOW on the next edge.
- Reset state (async, immediate on `rst`=0, including mid-qualification):
  - `s1`=`s2`=0, state=S_LOW, cnt=0.
  - Outputs: `btnOut`=0, `busy`=0, `glitchCnt`=0.
  - After reset release, a held-high input is qualified as a fresh press.

## Timing
- With `btnIn` stable from before edge 1:
  - `s2` changes after edge 2.
  - The FSM enters CHK after edge 3, so `busy` rises after edge 3.
  - `btnOut` changes and `busy` falls after edge STABLE_CYCLES+3.
- Minimum accepted pulse: STABLE_CYCLES+1 cycles of stable `s2` (one cycle to enter CHK plus STABLE_CYCLES in CHK). Any shorter excursion is rejected and counted.
- `glitchCnt` updates on the edge that leaves CHK due to a revert.
- Debounced release follows the same latency as press.

## Configuration
- Macro `DEBOUNCE_GLITCH_CNT_EN`.
- Defined: the 8-bit saturating glitch counter is built and driven onto `glitchCnt` as specified.
- Undefined: the counter logic is not built and `glitchCnt` is tied to 8'h00. Debounce behaviour is otherwise identical.

## Test plan
All scenarios use STABLE_CYCLES=4, CNT_W=3 and `DEBOUNCE_GLITCH_CNT_EN` defined, with all edge numbers counted from the first edge at which the new input level is sampled.
- Reset and first press:
  - Hold `rst`=0 with `btnIn`=1: `btnOut`=0, `busy`=0, `glitchCnt`=0.
  - Release `rst` and hold `btnIn`=1: `busy`=1 after edge 3; `btnOut`=1 and `busy`=0 after edge 7.
- Short pulse: `btnIn` high for 3 cycles, then low -> `btnOut` stays 0 and `glitchCnt`=1 after the revert.
- Bounce then press: toggle `btnIn` every cycle for 5 changes, then hold 1 -> `glitchCnt` increments per rejected excursion and `btnOut` rises after edge 7 counted from the final edge.
- Release and simultaneous revert: from S_HIGH, drop `btnIn` -> `btnOut`=0 after edge 7. Then, in a separate run, revert `s2` exactly when cnt==3 -> `btnOut` unchanged and `glitchCnt`+1.
- Saturation: 300 rejected glitches -> `glitchCnt`=8'hFF and holds.
- Reset mid-qualification: assert `rst` while cnt=2 in S_CHK_H -> `busy`=0, `btnOut`=0 and `glitchCnt`=0 immediately, without waiting for a clock edge.
